hazard_forward_unit: RTL and testbench
======================================

# hazard_forward_unit

Pipeline hazard controller for the 5-stage core. It keeps shadow copies of the register addresses and control bits for the instructions in EX, MEM and WB, and compares them against the source registers of the ID and EX instructions. From those comparisons it drives the forwarding-mux selects, a one-cycle load-use stall and a full-pipeline freeze while data memory is busy. It sits beside the ID/EX pipeline register and feeds the EX-stage operand muxes and the IF/ID stall and flush controls.

## Interface
Parameters:
- REG_ADDR_W, 4, register-address width (16 architectural registers; address 0 is an ordinary register).
- CNT_W, 16, width of the stall-cycle performance counter.

Ports:
- clk  in  1  single core clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- id_valid  in  1  ID holds a real instruction.
- id_rs1, id_rs2  in  REG_ADDR_W  ID source addresses.
- id_use_rs1, id_use_rs2  in  1  the ID instruction actually reads that source.
- id_rd  in  REG_ADDR_W  ID destination address.
- id_we  in  1  the ID instruction writes id_rd.
- id_is_load  in  1  the ID instruction is a load.
- mem_stall  in  1  data memory not ready; the whole pipeline must freeze.
- fwd_a, fwd_b  out  2  EX operand select: 00 register file, 01 EX/MEM result, 10 MEM/WB result.
- stall_if_id  out  1  hold PC and IF/ID.
- bubble_ex  out  1  load a NOP into ID/EX at the next edge.
- freeze_all  out  1  hold every pipeline register.
- stall_cycles  out  CNT_W  saturating count of cycles with stall_if_id=1.

## Operation
- Shadow stages:
  - EX: {valid, rs1, rs2, use1, use2, rd, we, ld}.
  - MEM: {valid, rd, we, ld}.
  - WB: {valid, rd, we}.
- Advance rule: on each edge with freeze_all=0, WB←MEM, MEM←EX, and EX←ID fields.
  - If bubble_ex=1 or id_valid=0, EX.valid←0 instead.
- A destination "matches" a source when all of these hold: the producer stage is valid, its we=1, the consumer's use flag is 1, and the addresses are equal.
- Forwarding (combinational, from EX sources):
  - fwd_a=01 if EX.rs1 matches MEM and MEM.ld=0.
  - Otherwise fwd_a=10 if EX.rs1 matches WB.
  - Otherwise fwd_a=00.
  - MEM takes priority over WB. fwd_b is identical using rs2.
- Load-use hazard: EX.ld=1 and (id_rs1 or id_rs2) matches EX, with id_valid=1.
- FSM states:
  - RUN: mem_stall=1 → MEM_WAIT. Else load-use → LU_STALL. Else stay in RUN.
  - LU_STALL: mem_stall=1 → MEM_WAIT. Else → RUN. This state lasts exactly one cycle.
  - MEM_WAIT: stays while mem_stall=1. When mem_stall=0 → RUN, and hazards are re-evaluated combinationally in that same cycle.
- Outputs per state:
  - stall_if_id = load_use_now (any state) OR freeze_all.
  - bubble_ex = load_use_now AND NOT mem_stall.
  - freeze_all = mem_stall (combinational, not registered).
- Counter: increments on every cycle with stall_if_id=1 and saturates at all-ones (no wrap).

## Timing
- Reset (async, rst_n=0) forces the following; all outputs take these values during and immediately after reset:
  - All shadow valid bits cleared.
  - FSM in RUN.
  - fwd_a=fwd_b=00.
  - stall_if_id=bubble_ex=freeze_all=0, except that freeze_all follows mem_stall.
  - stall_cycles=0.
- fwd_*, stall_if_id, bubble_ex and freeze_all are combinational from the current shadow state and inputs, with zero-cycle latency.
- Load-use costs exactly one bubble. Example: load in EX at cycle N, dependent instruction in ID at N. Then stall_if_id=1 and bubble_ex=1 at N. At N+1 the load is in MEM, the dependent is still in ID with no stall, and at N+2 the dependent in EX gets fwd=10.
- mem_stall asserted together with a load-use condition: the freeze wins. The shadows hold, no bubble is inserted, and the hazard is re-detected once mem_stall drops.
- Reset asserted mid-stall aborts immediately. The pipeline then restarts in RUN with empty shadows.

## Structure
- Package hazard_pkg holds:
  - REG_ADDR_W default.
  - fwd_sel_t enum {FWD_RF=2'b00, FWD_EXMEM=2'b01, FWD_MEMWB=2'b10}.
  - hz_state_t enum {RUN, LU_STALL, MEM_WAIT}.
  - Packed shadow-stage structs.
- Sub-module addr_match: qualified REG_ADDR_W equality (valid, we, use, addr_a, addr_b → hit). Instantiate it once per producer/consumer pair: 4 for forwarding, 2 for load-use.

## Test plan
- ADD r3 followed by SUB using r3 → at the cycle SUB is in EX, fwd_a=01; no stall.
- ADD r3, NOP, SUB r3 → fwd_a=10. ADD r3 then ADD r3 then SUB r3 → fwd_a=01 (MEM priority).
- LOAD r5 followed by ADD r5 → stall_if_id=1 and bubble_ex=1 for exactly one cycle, then fwd_b=10; stall_cycles=1.
- Load-use with mem_stall=1 for 3 cycles starting the same cycle → freeze_all=1 for 3 cycles and no bubble; then 1 bubble cycle; stall_cycles=4.
- id_use_rs1=0, or producer we=0, or producer valid=0, with equal addresses → fwd=00 and no stall.
- rst_n pulsed low during LU_STALL → all outputs 0 asynchronously and shadows empty. Then drive a stall-forcing sequence until the counter reaches 0xFFFF and confirm it holds there.

Source files
------------

// File: rtl/hazard_forward_unit_pkg.sv
// Shared types for the pipeline hazard/forwarding controller: mux selects, FSM states and
// the shadow copies of the EX, MEM and WB instructions.
package hazard_pkg;

    localparam int unsigned HZ_REG_ADDR_W = 4;

    typedef enum logic [1:0] {
        FWD_RF    = 2'b00,
        FWD_EXMEM = 2'b01,
        FWD_MEMWB = 2'b10
    } fwd_sel_t;

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        LU_STALL = 2'b01,
        MEM_WAIT = 2'b10
    } hz_state_t;

    typedef struct packed {
        logic                     valid;
        logic [HZ_REG_ADDR_W-1:0] rs1;
        logic [HZ_REG_ADDR_W-1:0] rs2;
        logic                     use1;
        logic                     use2;
        logic [HZ_REG_ADDR_W-1:0] rd;
        logic                     we;
        logic                     ld;
    } ex_shadow_t;

    typedef struct packed {
        logic                     valid;
        logic [HZ_REG_ADDR_W-1:0] rd;
        logic                     we;
        logic                     ld;
    } mem_shadow_t;

    typedef struct packed {
        logic                     valid;
        logic [HZ_REG_ADDR_W-1:0] rd;
        logic                     we;
    } wb_shadow_t;

endpackage

// File: rtl/hazard_forward_unit_if.sv
// ID-stage instruction fields and memory-stall input toward the hazard unit, plus its
// forwarding selects, stall/flush controls and stall-cycle counter.
interface hazard_forward_unit_if #(
    parameter int unsigned REG_ADDR_W = 4,
    parameter int unsigned CNT_W      = 16
);
    logic                  id_valid;
    logic [REG_ADDR_W-1:0] id_rs1;
    logic [REG_ADDR_W-1:0] id_rs2;
    logic                  id_use_rs1;
    logic                  id_use_rs2;
    logic [REG_ADDR_W-1:0] id_rd;
    logic                  id_we;
    logic                  id_is_load;
    logic                  mem_stall;
    logic [1:0]            fwd_a;
    logic [1:0]            fwd_b;
    logic                  stall_if_id;
    logic                  bubble_ex;
    logic                  freeze_all;
    logic [CNT_W-1:0]      stall_cycles;

    modport master (
        output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd, id_we, id_is_load,
        output mem_stall,
        input  fwd_a, fwd_b, stall_if_id, bubble_ex, freeze_all, stall_cycles
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd, id_we, id_is_load,
        input  mem_stall,
        output fwd_a, fwd_b, stall_if_id, bubble_ex, freeze_all, stall_cycles
    );
endinterface

// File: rtl/hazard_forward_unit_addr_match.sv
// Qualified register-address compare: a producer destination hits a consumer source only
// when the producer is valid and writes, and the consumer really reads that source.
module addr_match #(
    parameter int unsigned ADDR_W = 4
) (
    input  logic              i_valid,
    input  logic              i_we,
    input  logic              i_use,
    input  logic [ADDR_W-1:0] i_addr_a,
    input  logic [ADDR_W-1:0] i_addr_b,
    output logic              o_hit
);
    assign o_hit = i_valid & i_we & i_use & (i_addr_a == i_addr_b);
endmodule

// File: rtl/hazard_forward_unit.sv
// Hazard controller for the 5-stage core: shadows EX/MEM/WB, drives EX forwarding selects,
// the one-bubble load-use stall, the memory-busy freeze and a saturating stall counter.
module hazard_forward_unit
    import hazard_pkg::*;
#(
    parameter int unsigned REG_ADDR_W = HZ_REG_ADDR_W,
    parameter int unsigned CNT_W      = 16
) (
    input logic                clk,
    input logic                rst_n,
    hazard_forward_unit_if.slave bus
);

    ex_shadow_t  r_ex;
    mem_shadow_t r_mem;
    wb_shadow_t  r_wb;
    hz_state_t   r_state;
    logic [CNT_W-1:0] r_cnt;

    logic     w_a_mem, w_a_wb, w_b_mem, w_b_wb;
    logic     w_lu_rs1, w_lu_rs2, w_load_use;
    logic     w_freeze, w_stall, w_bubble;
    logic     w_ex_use1, w_ex_use2, w_id_use1, w_id_use2;
    fwd_sel_t w_fwd_a, w_fwd_b;

    // A squashed EX slot reads nothing, so it must never pick up a forward.
    assign w_ex_use1 = r_ex.valid & r_ex.use1;
    assign w_ex_use2 = r_ex.valid & r_ex.use2;
    assign w_id_use1 = bus.id_valid & bus.id_use_rs1;
    assign w_id_use2 = bus.id_valid & bus.id_use_rs2;

    addr_match #(.ADDR_W(REG_ADDR_W)) u_match_a_mem (
        .i_valid(r_mem.valid), .i_we(r_mem.we), .i_use(w_ex_use1),
        .i_addr_a(r_mem.rd), .i_addr_b(r_ex.rs1), .o_hit(w_a_mem)
    );
    addr_match #(.ADDR_W(REG_ADDR_W)) u_match_a_wb (
        .i_valid(r_wb.valid), .i_we(r_wb.we), .i_use(w_ex_use1),
        .i_addr_a(r_wb.rd), .i_addr_b(r_ex.rs1), .o_hit(w_a_wb)
    );
    addr_match #(.ADDR_W(REG_ADDR_W)) u_match_b_mem (
        .i_valid(r_mem.valid), .i_we(r_mem.we), .i_use(w_ex_use2),
        .i_addr_a(r_mem.rd), .i_addr_b(r_ex.rs2), .o_hit(w_b_mem)
    );
    addr_match #(.ADDR_W(REG_ADDR_W)) u_match_b_wb (
        .i_valid(r_wb.valid), .i_we(r_wb.we), .i_use(w_ex_use2),
        .i_addr_a(r_wb.rd), .i_addr_b(r_ex.rs2), .o_hit(w_b_wb)
    );
    addr_match #(.ADDR_W(REG_ADDR_W)) u_match_lu_rs1 (
        .i_valid(r_ex.valid), .i_we(r_ex.we), .i_use(w_id_use1),
        .i_addr_a(r_ex.rd), .i_addr_b(bus.id_rs1), .o_hit(w_lu_rs1)
    );
    addr_match #(.ADDR_W(REG_ADDR_W)) u_match_lu_rs2 (
        .i_valid(r_ex.valid), .i_we(r_ex.we), .i_use(w_id_use2),
        .i_addr_a(r_ex.rd), .i_addr_b(bus.id_rs2), .o_hit(w_lu_rs2)
    );

    // A load in MEM has no data yet; only its WB copy may be forwarded.
    always_comb begin
        w_fwd_a = FWD_RF;
        w_fwd_b = FWD_RF;
        if (w_a_mem && !r_mem.ld) w_fwd_a = FWD_EXMEM;
        else if (w_a_wb)          w_fwd_a = FWD_MEMWB;
        if (w_b_mem && !r_mem.ld) w_fwd_b = FWD_EXMEM;
        else if (w_b_wb)          w_fwd_b = FWD_MEMWB;
    end

    assign w_load_use = r_ex.ld & (w_lu_rs1 | w_lu_rs2);
    assign w_freeze   = bus.mem_stall;
    assign w_stall    = w_load_use | w_freeze;
    assign w_bubble   = w_load_use & ~bus.mem_stall;

    assign bus.fwd_a        = w_fwd_a;
    assign bus.fwd_b        = w_fwd_b;
    assign bus.stall_if_id  = w_stall;
    assign bus.bubble_ex    = w_bubble;
    assign bus.freeze_all   = w_freeze;
    assign bus.stall_cycles = r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= RUN;
        end else begin
            unique case (r_state)
                RUN: begin
                    if (bus.mem_stall)   r_state <= MEM_WAIT;
                    else if (w_load_use) r_state <= LU_STALL;
                end
                LU_STALL: r_state <= bus.mem_stall ? MEM_WAIT : RUN;
                MEM_WAIT: if (!bus.mem_stall) r_state <= RUN;
                default:  r_state <= RUN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex  <= '0;
            r_mem <= '0;
            r_wb  <= '0;
        end else if (!w_freeze) begin
            r_wb.valid  <= r_mem.valid;
            r_wb.rd     <= r_mem.rd;
            r_wb.we     <= r_mem.we;
            r_mem.valid <= r_ex.valid;
            r_mem.rd    <= r_ex.rd;
            r_mem.we    <= r_ex.we;
            r_mem.ld    <= r_ex.ld;
            r_ex.valid  <= bus.id_valid & ~w_bubble;
            r_ex.rs1    <= bus.id_rs1;
            r_ex.rs2    <= bus.id_rs2;
            r_ex.use1   <= bus.id_use_rs1;
            r_ex.use2   <= bus.id_use_rs2;
            r_ex.rd     <= bus.id_rd;
            r_ex.we     <= bus.id_we;
            r_ex.ld     <= bus.id_is_load;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (w_stall && (r_cnt != {CNT_W{1'b1}})) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Directed bench for hazard_forward_unit: forwarding priority, load-use bubble, memory
// freeze, qualification corner cases, async reset and counter saturation.
module tb_hazard_forward_unit;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    hazard_forward_unit_if #(.REG_ADDR_W(4), .CNT_W(16)) bus ();

    hazard_forward_unit #(.REG_ADDR_W(4), .CNT_W(16)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive the ID stage and let the combinational outputs settle.
    task automatic id(input logic v, input logic [3:0] rs1, input logic [3:0] rs2,
                      input logic u1, input logic u2, input logic [3:0] rd,
                      input logic we, input logic ld);
        bus.id_valid   = v;
        bus.id_rs1     = rs1;
        bus.id_rs2     = rs2;
        bus.id_use_rs1 = u1;
        bus.id_use_rs2 = u2;
        bus.id_rd      = rd;
        bus.id_we      = we;
        bus.id_is_load = ld;
        #1;
    endtask

    task automatic nop();
        id(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic flush();
        nop();
        repeat (4) tick();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #3;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    task automatic chk_ctl(input string tag, input logic st, input logic bb, input logic fz);
        chk({tag, ".stall"},  {31'd0, bus.stall_if_id}, {31'd0, st});
        chk({tag, ".bubble"}, {31'd0, bus.bubble_ex},   {31'd0, bb});
        chk({tag, ".freeze"}, {31'd0, bus.freeze_all},  {31'd0, fz});
    endtask

    initial begin
        total = 0;
        bad   = 0;
        bus.mem_stall = 1'b1;
        rst_n = 1'b0;
        nop();
        #2;
        chk("rst.freeze_follows", {31'd0, bus.freeze_all}, 32'd1);
        bus.mem_stall = 1'b0;
        #1;
        chk("rst.fwd_a", {30'd0, bus.fwd_a}, 32'd0);
        chk("rst.fwd_b", {30'd0, bus.fwd_b}, 32'd0);
        chk_ctl("rst", 1'b0, 1'b0, 1'b0);
        chk("rst.cnt", {16'd0, bus.stall_cycles}, 32'd0);
        do_reset();

        // ADD r3 ; SUB r3 -> EX/MEM forward
        id(1'b1, 4'd1, 4'd2, 1'b1, 1'b1, 4'd3, 1'b1, 1'b0);
        tick();
        id(1'b1, 4'd3, 4'd4, 1'b1, 1'b1, 4'd6, 1'b1, 1'b0);
        chk_ctl("t1.id", 1'b0, 1'b0, 1'b0);
        tick();
        nop();
        chk("t1.fwd_a", {30'd0, bus.fwd_a}, 32'd1);
        chk("t1.fwd_b", {30'd0, bus.fwd_b}, 32'd0);
        chk_ctl("t1.ex", 1'b0, 1'b0, 1'b0);
        flush();

        // ADD r3 ; NOP ; SUB r3 -> MEM/WB forward
        id(1'b1, 4'd1, 4'd2, 1'b1, 1'b1, 4'd3, 1'b1, 1'b0);
        tick();
        nop();
        tick();
        id(1'b1, 4'd3, 4'd4, 1'b1, 1'b1, 4'd6, 1'b1, 1'b0);
        tick();
        nop();
        chk("t2.fwd_a", {30'd0, bus.fwd_a}, 32'd2);
        flush();

        // ADD r3 ; ADD r3 ; SUB r3 -> MEM wins over WB
        id(1'b1, 4'd1, 4'd2, 1'b1, 1'b1, 4'd3, 1'b1, 1'b0);
        tick();
        id(1'b1, 4'd7, 4'd8, 1'b1, 1'b1, 4'd3, 1'b1, 1'b0);
        tick();
        id(1'b1, 4'd3, 4'd3, 1'b1, 1'b1, 4'd6, 1'b1, 1'b0);
        tick();
        nop();
        chk("t3.fwd_a", {30'd0, bus.fwd_a}, 32'd1);
        chk("t3.fwd_b", {30'd0, bus.fwd_b}, 32'd1);
        flush();

        // LOAD r5 ; ADD r6,r5 -> one bubble then MEM/WB forward on rs2
        id(1'b1, 4'd1, 4'd0, 1'b1, 1'b0, 4'd5, 1'b1, 1'b1);
        tick();
        id(1'b1, 4'd6, 4'd5, 1'b1, 1'b1, 4'd7, 1'b1, 1'b0);
        chk_ctl("t4.lu", 1'b1, 1'b1, 1'b0);
        tick();
        chk_ctl("t4.after", 1'b0, 1'b0, 1'b0);
        tick();
        nop();
        chk("t4.fwd_b", {30'd0, bus.fwd_b}, 32'd2);
        chk("t4.fwd_a", {30'd0, bus.fwd_a}, 32'd0);
        chk("t4.cnt", {16'd0, bus.stall_cycles}, 32'd1);
        flush();

        // Qualification: consumer use=0, producer we=0, producer invalid
        id(1'b1, 4'd1, 4'd2, 1'b1, 1'b1, 4'd3, 1'b1, 1'b0);
        tick();
        id(1'b1, 4'd3, 4'd3, 1'b0, 1'b0, 4'd6, 1'b1, 1'b0);
        tick();
        nop();
        chk("t6.use0", {28'd0, bus.fwd_a, bus.fwd_b}, 32'd0);
        flush();
        id(1'b1, 4'd1, 4'd2, 1'b1, 1'b1, 4'd3, 1'b0, 1'b0);
        tick();
        id(1'b1, 4'd3, 4'd3, 1'b1, 1'b1, 4'd6, 1'b1, 1'b0);
        tick();
        nop();
        chk("t6.we0", {28'd0, bus.fwd_a, bus.fwd_b}, 32'd0);
        flush();
        id(1'b0, 4'd1, 4'd2, 1'b1, 1'b1, 4'd3, 1'b1, 1'b0);
        tick();
        id(1'b1, 4'd3, 4'd3, 1'b1, 1'b1, 4'd6, 1'b1, 1'b0);
        tick();
        nop();
        chk("t6.valid0", {28'd0, bus.fwd_a, bus.fwd_b}, 32'd0);
        flush();
        id(1'b1, 4'd1, 4'd0, 1'b1, 1'b0, 4'd5, 1'b0, 1'b1);
        tick();
        id(1'b1, 4'd5, 4'd5, 1'b1, 1'b1, 4'd7, 1'b1, 1'b0);
        chk_ctl("t6.ld_we0", 1'b0, 1'b0, 1'b0);
        id(1'b1, 4'd5, 4'd5, 1'b0, 1'b0, 4'd7, 1'b1, 1'b0);
        chk_ctl("t6.ld_use0", 1'b0, 1'b0, 1'b0);
        flush();
        chk("t6.cnt", {16'd0, bus.stall_cycles}, 32'd1);

        // Load-use with a 3-cycle memory stall starting the same cycle
        do_reset();
        id(1'b1, 4'd1, 4'd0, 1'b1, 1'b0, 4'd5, 1'b1, 1'b1);
        tick();
        bus.mem_stall = 1'b1;
        id(1'b1, 4'd5, 4'd0, 1'b1, 1'b0, 4'd7, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            chk_ctl($sformatf("t5.frz%0d", i), 1'b1, 1'b0, 1'b1);
            tick();
        end
        bus.mem_stall = 1'b0;
        #1;
        chk_ctl("t5.lu", 1'b1, 1'b1, 1'b0);
        tick();
        chk_ctl("t5.after", 1'b0, 1'b0, 1'b0);
        chk("t5.cnt", {16'd0, bus.stall_cycles}, 32'd4);
        tick();
        nop();
        chk("t5.fwd_a", {30'd0, bus.fwd_a}, 32'd2);
        flush();

        // Async reset during LU_STALL
        do_reset();
        id(1'b1, 4'd1, 4'd0, 1'b1, 1'b0, 4'd5, 1'b1, 1'b1);
        tick();
        id(1'b1, 4'd5, 4'd0, 1'b1, 1'b0, 4'd7, 1'b1, 1'b0);
        chk("t7.pre_stall", {31'd0, bus.stall_if_id}, 32'd1);
        tick();
        chk("t7.pre_cnt", {16'd0, bus.stall_cycles}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t7.cnt", {16'd0, bus.stall_cycles}, 32'd0);
        chk_ctl("t7.rst", 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        #1;
        tick();
        chk("t7.fwd_a", {30'd0, bus.fwd_a}, 32'd0);
        chk_ctl("t7.run", 1'b0, 1'b0, 1'b0);
        flush();

        // Counter saturation
        do_reset();
        bus.mem_stall = 1'b1;
        #1;
        repeat (65535) @(posedge clk);
        #1;
        chk("t8.cnt_max", {16'd0, bus.stall_cycles}, 32'h0000FFFF);
        repeat (3) @(posedge clk);
        #1;
        chk("t8.cnt_hold", {16'd0, bus.stall_cycles}, 32'h0000FFFF);
        bus.mem_stall = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
